// File: rtl/rasterizer_backend_span.sv
// Span rasterizer back end: steps edges/z across a bbox, LANES pixels per beat.
// Option RASTER_EDGE_INCLUSIVE_EN: edge test is >= 0 instead of > 0.
module rasterizer_backend_span #(
  parameter int DATAWIDTH     = 12,
  parameter int COLORWIDTH    = 4,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int ADDRWIDTH     = 17,
  parameter int IDWIDTH       = 16,
  parameter int LANES         = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [1:0][DATAWIDTH-1:0]      bb_tl,
  input  logic [1:0][DATAWIDTH-1:0]      bb_br,
  input  logic [2*DATAWIDTH-1:0]         edge_val0,
  input  logic [2*DATAWIDTH-1:0]         edge_val1,
  input  logic [2*DATAWIDTH-1:0]         edge_val2,
  input  logic [1:0][DATAWIDTH-1:0]      edge_delta0,
  input  logic [1:0][DATAWIDTH-1:0]      edge_delta1,
  input  logic [1:0][DATAWIDTH-1:0]      edge_delta2,
  input  logic [DATAWIDTH-1:0]           z,
  input  logic [1:0][DATAWIDTH-1:0]      z_delta,
  input  logic [IDWIDTH-1:0]             id,
  input  logic                           i_dv,
  input  logic                           i_last,
  output logic                           ready,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [ADDRWIDTH-1:0]           o_addr,
  output logic [LANES-1:0]               o_mask,
  output logic [LANES*DATAWIDTH-1:0]     o_depth,
  output logic [COLORWIDTH-1:0]          o_color,
  output logic                           done,
  output logic                           finished
);
  localparam int DW = DATAWIDTH;
  localparam int EW = 2 * DATAWIDTH;
  localparam int XW = DATAWIDTH + 2;
  localparam int AW = ADDRWIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, RASTER, DONE} state_t;

  state_t               state_q;
  logic signed [XW-1:0] tlx_q, tly_q, brx_q, bry_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [EW-1:0] dx_q [3];
  logic signed [EW-1:0] dy_q [3];
  logic signed [EW-1:0] e_q [3];
  logic signed [EW-1:0] re_q [3];
  logic signed [EW-1:0] estr_q [3];
  logic signed [EW-1:0] eoff_q [3][LANES];
  logic [DW-1:0]        zx_q, zy_q, z_q, rz_q, zstr_q;
  logic [DW-1:0]        zoff_q [LANES];
  logic [AW-1:0]        addr_q, raddr_q;
  logic                 more_q, last_q;

  logic [EW-1:0]        ev_w [3];
  logic [1:0][DW-1:0]   ed_w [3];
  logic [LANES-1:0]     mask_c;
  logic [LANES*DW-1:0]  depth_c;
  logic                 unused_w;

  assign ev_w[0] = edge_val0;
  assign ev_w[1] = edge_val1;
  assign ev_w[2] = edge_val2;
  assign ed_w[0] = edge_delta0;
  assign ed_w[1] = edge_delta1;
  assign ed_w[2] = edge_delta2;
  assign ready   = (state_q == IDLE);
  assign unused_w = ^{id, SCREEN_HEIGHT[0]};

  // Per-lane coverage and depth for the beat at the cursor.
  always_comb begin
    logic signed [XW-1:0] lx;
    logic signed [EW-1:0] le;
    logic                 cov;
    mask_c  = '0;
    depth_c = '0;
    lx      = '0;
    le      = '0;
    cov     = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lx  = x_q + XW'(k);
      cov = (lx <= brx_q);
      for (int j = 0; j < 3; j++) begin
        le = e_q[j] + eoff_q[j][k];
`ifdef RASTER_EDGE_INCLUSIVE_EN
        cov = cov && (le >= 0);
`else
        cov = cov && (le > 0);
`endif
      end
      mask_c[k] = cov;
      depth_c[k*DW +: DW] = z_q + zoff_q[k];
    end
  end

  // Triangle FSM, cursor stepping and registered beat outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      o_valid  <= 1'b0;
      o_mask   <= '0;
      o_addr   <= '0;
      o_depth  <= '0;
      o_color  <= '0;
      done     <= 1'b0;
      finished <= 1'b0;
      more_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      done     <= 1'b0;
      finished <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_dv) begin
            tlx_q   <= XW'($signed(bb_tl[0]));
            tly_q   <= XW'($signed(bb_tl[1]));
            brx_q   <= XW'($signed(bb_br[0]));
            bry_q   <= XW'($signed(bb_br[1]));
            x_q     <= XW'($signed(bb_tl[0]));
            y_q     <= XW'($signed(bb_tl[1]));
            for (int j = 0; j < 3; j++) begin
              dx_q[j] <= EW'($signed(ed_w[j][0]));
              dy_q[j] <= EW'($signed(ed_w[j][1]));
              e_q[j]  <= $signed(ev_w[j]);
              re_q[j] <= $signed(ev_w[j]);
            end
            zx_q    <= z_delta[0];
            zy_q    <= z_delta[1];
            z_q     <= z;
            rz_q    <= z;
            o_color <= id[COLORWIDTH-1:0];
            last_q  <= i_last;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          for (int j = 0; j < 3; j++) begin
            estr_q[j] <= dx_q[j] * EW'(LANES);
            for (int k = 0; k < LANES; k++)
              eoff_q[j][k] <= dx_q[j] * EW'(k);
          end
          zstr_q <= zx_q * DW'(LANES);
          for (int k = 0; k < LANES; k++)
            zoff_q[k] <= zx_q * DW'(k);
          addr_q  <= AW'(tly_q) * AW'(SCREEN_WIDTH) + AW'(tlx_q);
          raddr_q <= AW'(tly_q) * AW'(SCREEN_WIDTH) + AW'(tlx_q);
          more_q  <= 1'b1;
          if (brx_q < tlx_q || bry_q < tly_q)
            state_q <= DONE;
          else
            state_q <= RASTER;
        end
        RASTER: begin
          if (!o_valid || o_ready) begin
            if (more_q) begin
              o_valid <= 1'b1;
              o_addr  <= addr_q;
              o_mask  <= mask_c;
              o_depth <= depth_c;
              if (x_q + XW'(LANES) > brx_q) begin
                if (y_q == bry_q) begin
                  more_q <= 1'b0;
                end else begin
                  y_q     <= y_q + XW'(1);
                  x_q     <= tlx_q;
                  for (int j = 0; j < 3; j++) begin
                    re_q[j] <= re_q[j] + dy_q[j];
                    e_q[j]  <= re_q[j] + dy_q[j];
                  end
                  rz_q    <= rz_q + zy_q;
                  z_q     <= rz_q + zy_q;
                  raddr_q <= raddr_q + AW'(SCREEN_WIDTH);
                  addr_q  <= raddr_q + AW'(SCREEN_WIDTH);
                end
              end else begin
                x_q    <= x_q + XW'(LANES);
                for (int j = 0; j < 3; j++)
                  e_q[j] <= e_q[j] + estr_q[j];
                z_q    <= z_q + zstr_q;
                addr_q <= addr_q + AW'(LANES);
              end
            end else begin
              o_valid <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          finished <= last_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rasterizer_backend_span.sv
// Directed self-checking bench for rasterizer_backend_span (LANES=4).
module tb_rasterizer_backend_span;
  localparam int DW = 12;
  localparam int L  = 4;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0][DW-1:0] bb_tl, bb_br;
  logic [2*DW-1:0] edge_val0, edge_val1, edge_val2;
  logic [1:0][DW-1:0] edge_delta0, edge_delta1, edge_delta2, z_delta;
  logic [DW-1:0] z;
  logic [15:0] id;
  logic i_dv, i_last, o_ready;
  logic ready, o_valid, done, finished;
  logic [AW-1:0] o_addr;
  logic [L-1:0] o_mask;
  logic [L*DW-1:0] o_depth;
  logic [3:0] o_color;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] cap_addr[$];
  logic [L-1:0] cap_mask[$];
  logic [L*DW-1:0] cap_depth[$];
  int first_cyc, done_cyc;
  logic fin_seen;

  rasterizer_backend_span dut (
    .clk(clk), .rstn(rstn), .bb_tl(bb_tl), .bb_br(bb_br),
    .edge_val0(edge_val0), .edge_val1(edge_val1), .edge_val2(edge_val2),
    .edge_delta0(edge_delta0), .edge_delta1(edge_delta1),
    .edge_delta2(edge_delta2), .z(z), .z_delta(z_delta), .id(id),
    .i_dv(i_dv), .i_last(i_last), .ready(ready), .o_valid(o_valid),
    .o_ready(o_ready), .o_addr(o_addr), .o_mask(o_mask),
    .o_depth(o_depth), .o_color(o_color), .done(done),
    .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic set_tri(input int tx, input int ty, input int bx, input int by);
    bb_tl[0] = DW'(tx); bb_tl[1] = DW'(ty);
    bb_br[0] = DW'(bx); bb_br[1] = DW'(by);
    edge_val0 = 24'd100; edge_val1 = 24'd100; edge_val2 = 24'd100;
    edge_delta0 = '0; edge_delta1 = '0; edge_delta2 = '0;
    z = '0; z_delta = '0; id = '0; i_last = 1'b0;
  endtask

  task automatic send();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait: ready=%b required 1", ready);
    end
    i_dv = 1'b1;
    @(posedge clk); #1;
    i_dv = 1'b0;
  endtask

  task automatic capture();
    cap_addr.delete(); cap_mask.delete(); cap_depth.delete();
    first_cyc = -1; done_cyc = -1; fin_seen = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        if (first_cyc < 0) first_cyc = c;
        cap_addr.push_back(o_addr);
        cap_mask.push_back(o_mask);
        cap_depth.push_back(o_depth);
      end
      if (done) begin
        done_cyc = c;
        fin_seen = finished;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_dv = 1'b0; o_ready = 1'b1;
    set_tri(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    checks += 6;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    if (o_mask !== 4'b0) begin errors++; $display("FAIL rst_mask: got %b want 0000", o_mask); end
    if (o_addr !== 17'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", o_addr); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (finished !== 1'b0) begin errors++; $display("FAIL rst_finished: got %b want 0", finished); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea [4];
    ea = '{17'd0, 17'd4, 17'd320, 17'd324};
    set_tri(0, 0, 7, 1);
    id = 16'h1235;
    send();
    capture();
    checks += 5;
    if (cap_addr.size() != 4) begin errors++; $display("FAIL basic_beats: got %0d want 4", cap_addr.size()); end
    if (first_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", first_cyc); end
    if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cyc: got %0d want 7", done_cyc); end
    if (fin_seen !== 1'b0) begin errors++; $display("FAIL basic_finished: got %b want 0", fin_seen); end
    if (o_color !== 4'h5) begin errors++; $display("FAIL basic_color: got %h want 5", o_color); end
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
      checks += 2;
      if (cap_addr[i] !== ea[i]) begin errors++; $display("FAIL basic_addr%0d: got %0d want %0d", i, cap_addr[i], ea[i]); end
      if (cap_mask[i] !== 4'b1111) begin errors++; $display("FAIL basic_mask%0d: got %b want 1111", i, cap_mask[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_partial_span();
    set_tri(2, 0, 6, 0);
    send();
    capture();
    checks++;
    if (cap_addr.size() != 2) begin
      errors++; $display("FAIL span_beats: got %0d want 2", cap_addr.size());
    end else begin
      checks += 4;
      if (cap_addr[0] !== 17'd2) begin errors++; $display("FAIL span_addr0: got %0d want 2", cap_addr[0]); end
      if (cap_mask[0] !== 4'b1111) begin errors++; $display("FAIL span_mask0: got %b want 1111", cap_mask[0]); end
      if (cap_addr[1] !== 17'd6) begin errors++; $display("FAIL span_addr1: got %0d want 6", cap_addr[1]); end
      if (cap_mask[1] !== 4'b0001) begin errors++; $display("FAIL span_mask1: got %b want 0001", cap_mask[1]); end
    end
  endtask

  task automatic test_edge_mask();
    logic [L-1:0] em;
`ifdef RASTER_EDGE_INCLUSIVE_EN
    em = 4'b1110;
`else
    em = 4'b1100;
`endif
    set_tri(0, 0, 3, 0);
    edge_val0 = 24'hFFFFFF;
    edge_delta0[0] = 12'd1;
    edge_val1 = 24'd50;
    edge_val2 = 24'd50;
    send();
    capture();
    checks += 2;
    if (cap_addr.size() != 1) begin errors++; $display("FAIL edge_beats: got %0d want 1", cap_addr.size()); end
    if (cap_mask.size() < 1 || cap_mask[0] !== em) begin
      errors++; $display("FAIL edge_mask: got %b want %b", (cap_mask.size() > 0) ? cap_mask[0] : 4'bx, em);
    end
  endtask

  task automatic test_depth();
    logic [L*DW-1:0] d0, d1;
    d0 = {12'd91, 12'd94, 12'd97, 12'd100};
    d1 = {12'd101, 12'd104, 12'd107, 12'd110};
    set_tri(0, 0, 3, 1);
    z = 12'd100;
    z_delta[0] = 12'hFFD;
    z_delta[1] = 12'd10;
    send();
    capture();
    checks++;
    if (cap_depth.size() != 2) begin
      errors++; $display("FAIL depth_beats: got %0d want 2", cap_depth.size());
    end else begin
      checks += 3;
      if (cap_depth[0] !== d0) begin errors++; $display("FAIL depth_row0: got %h want %h", cap_depth[0], d0); end
      if (cap_depth[1] !== d1) begin errors++; $display("FAIL depth_row1: got %h want %h", cap_depth[1], d1); end
      if (cap_addr[1] !== 17'd320) begin errors++; $display("FAIL depth_addr1: got %0d want 320", cap_addr[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [L*DW-1:0] hd;
    hd = {12'd12, 12'd11, 12'd10, 12'd9};
    set_tri(0, 0, 15, 0);
    z = 12'd5;
    z_delta[0] = 12'd1;
    o_ready = 1'b1;
    send();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_addr !== 17'd0) begin
      errors++; $display("FAIL bp_first: valid=%b addr=%0d want 1/0", o_valid, o_addr);
    end
    @(posedge clk); #1;
    o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_addr !== 17'd4 || o_mask !== 4'b1111 || o_depth !== hd) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b addr=%0d mask=%b depth=%h want 1/4/1111/%h",
                 i, o_valid, o_addr, o_mask, o_depth, hd);
      end
    end
    o_ready = 1'b1;
    capture();
    checks++;
    if (cap_addr.size() != 2) begin
      errors++; $display("FAIL bp_rest_beats: got %0d want 2", cap_addr.size());
    end else begin
      checks += 2;
      if (cap_addr[0] !== 17'd8) begin errors++; $display("FAIL bp_addr8: got %0d want 8", cap_addr[0]); end
      if (cap_addr[1] !== 17'd12) begin errors++; $display("FAIL bp_addr12: got %0d want 12", cap_addr[1]); end
    end
  endtask

  task automatic test_degenerate();
    set_tri(5, 0, 3, 2);
    i_last = 1'b1;
    send();
    i_last = 1'b0;
    capture();
    checks += 3;
    if (cap_addr.size() != 0) begin errors++; $display("FAIL degen_beats: got %0d want 0", cap_addr.size()); end
    if (done_cyc != 2) begin errors++; $display("FAIL degen_done_cyc: got %0d want 2", done_cyc); end
    if (fin_seen !== 1'b1) begin errors++; $display("FAIL degen_finished: got %b want 1", fin_seen); end
  endtask

  task automatic test_reset_mid();
    set_tri(0, 0, 15, 3);
    send();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_active: got %b want 1", o_valid); end
    rstn = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", o_valid); end
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", ready); end
    rstn = 1'b1;
    set_tri(0, 0, 3, 0);
    send();
    capture();
    checks += 2;
    if (cap_addr.size() != 1) begin errors++; $display("FAIL mid_after_beats: got %0d want 1", cap_addr.size()); end
    if (done_cyc < 0) begin errors++; $display("FAIL mid_after_done: got none want pulse"); end
  endtask

  initial begin
    i_dv = 1'b0;
    o_ready = 1'b1;
    test_reset();
    test_basic();
    test_partial_span();
    test_edge_mask();
    test_depth();
    test_backpressure();
    test_degenerate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
